// File: rtl/node_pkg.sv
// Shared node definitions: flit geometry, packet-type encodings and source ids.
// Also used by config_ctrl.
package node_pkg;

   localparam int unsigned FW  = 59;
   localparam int unsigned FTW = 3;

   typedef enum logic [FTW-1:0] {
      PktSpike   = 3'b000,
      PktData    = 3'b001,
      PktDataEnd = 3'b010,
      PktWrite   = 3'b110,
      PktRead    = 3'b111
   } pkt_type_e;

   typedef enum logic {
      SrcConfig = 1'b0,
      SrcSoma   = 1'b1
   } src_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count; full/empty decode from the count.
module sync_fifo #(
   parameter int unsigned W     = 8,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);

   localparam logic [AW:0] DepthCnt = (AW+1)'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q, count_d;
   logic          push_ok, pop_ok;

   assign full  = (count_q == DepthCnt);
   assign empty = (count_q == '0);
   assign count = count_q;
   assign dout  = mem_q[rd_ptr_q];

   // A push into a full FIFO is rejected even when a pop frees a slot this cycle.
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   always_comb begin
      count_d = count_q;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/spk_out_arb.sv
// Node output stage: two source FIFOs, round-robin arbiter and a registered
// valid/ready output towards the router.
module spk_out_arb #(
   parameter int unsigned FW    = node_pkg::FW,
   parameter int unsigned FTW   = node_pkg::FTW,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          config_spk_out_we,
   input  logic [FW-1:0] config_spk_out_wdata,
   output logic          spk_out_config_full,
   input  logic          soma_spk_out_we,
   input  logic [FW-1:0] soma_spk_out_wdata,
   output logic          spk_out_soma_full,
   output logic          spk_out_valid,
   output logic [FW-1:0] spk_out_data,
   input  logic          router_spk_out_ready,
   output logic [1:0]    spk_out_ovf
);

   import node_pkg::*;

   logic [FW-1:0] cfg_head, soma_head;
   logic          cfg_empty, soma_empty;
   logic          cfg_pop, soma_pop;
   logic [AW:0]   cfg_count, soma_count;

   logic          valid_q, valid_d;
   logic [FW-1:0] data_q, data_d;
   src_e          last_grant_q, last_grant_d;
   logic [1:0]    ovf_q, ovf_d;
   logic          load_en;

   sync_fifo #(
      .W     (FW),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_cfg_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (config_spk_out_we),
      .pop   (cfg_pop),
      .din   (config_spk_out_wdata),
      .dout  (cfg_head),
      .full  (spk_out_config_full),
      .empty (cfg_empty),
      .count (cfg_count)
   );

   sync_fifo #(
      .W     (FW),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_soma_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (soma_spk_out_we),
      .pop   (soma_pop),
      .din   (soma_spk_out_wdata),
      .dout  (soma_head),
      .full  (spk_out_soma_full),
      .empty (soma_empty),
      .count (soma_count)
   );

   // Arbitration and output-register load.
   always_comb begin
      valid_d      = valid_q;
      data_d       = data_q;
      last_grant_d = last_grant_q;
      cfg_pop      = 1'b0;
      soma_pop     = 1'b0;
      load_en      = !valid_q || router_spk_out_ready;
      if (load_en) begin
         if (!cfg_empty && (soma_empty || last_grant_q == SrcSoma)) begin
            cfg_pop      = 1'b1;
            data_d       = cfg_head;
            valid_d      = 1'b1;
            last_grant_d = SrcConfig;
         end else if (!soma_empty) begin
            soma_pop     = 1'b1;
            data_d       = soma_head;
            valid_d      = 1'b1;
            last_grant_d = SrcSoma;
         end else begin
            valid_d      = 1'b0;
         end
      end
   end

   assign ovf_d = ovf_q | {soma_spk_out_we && spk_out_soma_full,
                           config_spk_out_we && spk_out_config_full};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q      <= 1'b0;
         data_q       <= '0;
         last_grant_q <= SrcSoma;
         ovf_q        <= '0;
      end else begin
         valid_q      <= valid_d;
         data_q       <= data_d;
         last_grant_q <= last_grant_d;
         ovf_q        <= ovf_d;
      end
   end

   assign spk_out_valid = valid_q;
   assign spk_out_data  = data_q;
   assign spk_out_ovf   = ovf_q;

   // Flits pass through opaque; counts and the type field are not needed here.
   logic unused_sigs;
   assign unused_sigs = ^{cfg_count, soma_count, data_q[FW-1:FW-FTW]};

endmodule

// File: tb/tb_spk_out_arb.sv
// Self-checking bench for spk_out_arb: directed scenarios plus randomized streaming
// checked against a queue-based reference model.
module tb_spk_out_arb;

   localparam int unsigned FW    = 59;
   localparam int unsigned DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cfg_we = 1'b0;
   logic [FW-1:0] cfg_wdata = '0;
   logic          cfg_full;
   logic          soma_we = 1'b0;
   logic [FW-1:0] soma_wdata = '0;
   logic          soma_full;
   logic          out_valid;
   logic [FW-1:0] out_data;
   logic          ready = 1'b0;
   logic [1:0]    ovf;

   int n_checks = 0;
   int n_errors = 0;

   spk_out_arb #(
      .FW    (FW),
      .FTW   (3),
      .DEPTH (DEPTH),
      .AW    (2)
   ) u_dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .config_spk_out_we    (cfg_we),
      .config_spk_out_wdata (cfg_wdata),
      .spk_out_config_full  (cfg_full),
      .soma_spk_out_we      (soma_we),
      .soma_spk_out_wdata   (soma_wdata),
      .spk_out_soma_full    (soma_full),
      .spk_out_valid        (out_valid),
      .spk_out_data         (out_data),
      .router_spk_out_ready (ready),
      .spk_out_ovf          (ovf)
   );

   always #5 clk = ~clk;

   // Reference model: queues hold FIFO contents, one output slot, round-robin pointer.
   logic [FW-1:0] m_cfg[$];
   logic [FW-1:0] m_soma[$];
   logic          m_valid = 1'b0;
   logic [FW-1:0] m_data = '0;
   logic          m_last = 1'b1;
   logic [1:0]    m_ovf = 2'b00;
   bit            m_cfg_was_full, m_soma_was_full, m_take_soma;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cfg.delete();
         m_soma.delete();
         m_valid = 1'b0;
         m_data  = '0;
         m_last  = 1'b1;
         m_ovf   = 2'b00;
      end else begin
         m_cfg_was_full  = (m_cfg.size() == DEPTH);
         m_soma_was_full = (m_soma.size() == DEPTH);
         if (!m_valid || ready) begin
            if (m_cfg.size() > 0 || m_soma.size() > 0) begin
               m_take_soma = (m_soma.size() > 0) && (m_cfg.size() == 0 || m_last == 1'b0);
               if (m_take_soma) m_data = m_soma.pop_front();
               else             m_data = m_cfg.pop_front();
               m_valid = 1'b1;
               m_last  = m_take_soma;
            end else begin
               m_valid = 1'b0;
            end
         end
         if (cfg_we) begin
            if (m_cfg_was_full) m_ovf[0] = 1'b1;
            else                m_cfg.push_back(cfg_wdata);
         end
         if (soma_we) begin
            if (m_soma_was_full) m_ovf[1] = 1'b1;
            else                 m_soma.push_back(soma_wdata);
         end
      end
   end

   task automatic apply_reset();
      cfg_we  = 1'b0;
      soma_we = 1'b0;
      ready   = 1'b0;
      rst_n   = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      apply_reset();
      n_checks++;
      if (out_valid !== 1'b0 || out_data !== '0) begin
         n_errors++;
         $display("FAIL reset_out: valid=%b data=%h want 0/0", out_valid, out_data);
      end
      n_checks++;
      if (cfg_full !== 1'b0 || soma_full !== 1'b0 || ovf !== 2'b00) begin
         n_errors++;
         $display("FAIL reset_flags: cfg_full=%b soma_full=%b ovf=%b want 0 0 00",
                  cfg_full, soma_full, ovf);
      end
   endtask

   task automatic test_single();
      logic [FW-1:0] flit;
      flit = 59'h7_00_07_000_0ABCDE;
      apply_reset();
      ready     = 1'b1;
      cfg_we    = 1'b1;
      cfg_wdata = flit;
      @(negedge clk);
      cfg_we = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL single_no_bypass: valid=%b want 0", out_valid);
      end
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== flit) begin
         n_errors++;
         $display("FAIL single_out: valid=%b data=%h want 1 %h", out_valid, out_data, flit);
      end
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL single_drop: valid=%b want 0", out_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [FW-1:0] got[$];
      logic [FW-1:0] exp[8];
      for (int i = 0; i < 4; i++) begin
         exp[2*i]   = FW'(32'hC0 + i);
         exp[2*i+1] = FW'(32'h50 + i);
      end
      apply_reset();
      ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cfg_we     = 1'b1;
         cfg_wdata  = FW'(32'hC0 + i);
         soma_we    = 1'b1;
         soma_wdata = FW'(32'h50 + i);
         if (out_valid) got.push_back(out_data);
         @(negedge clk);
      end
      cfg_we  = 1'b0;
      soma_we = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (out_valid) got.push_back(out_data);
         @(negedge clk);
      end
      n_checks++;
      if (got.size() != 8) begin
         n_errors++;
         $display("FAIL b2b_count: got %0d flits want 8", got.size());
      end
      for (int i = 0; i < 8 && i < got.size(); i++) begin
         n_checks++;
         if (got[i] !== exp[i]) begin
            n_errors++;
            $display("FAIL b2b_order[%0d]: got %h want %h", i, got[i], exp[i]);
         end
      end
      n_checks++;
      if (ovf !== 2'b00) begin
         n_errors++;
         $display("FAIL b2b_ovf: got %b want 00", ovf);
      end
   endtask

   task automatic test_backpressure();
      logic [FW-1:0] got[$];
      apply_reset();
      ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         soma_we    = 1'b1;
         soma_wdata = FW'(32'h100 + i);
         @(negedge clk);
         if (i == 4) begin
            n_checks++;
            if (soma_full !== 1'b1) begin
               n_errors++;
               $display("FAIL bp_full: got %b want 1 after 5th write", soma_full);
            end
         end
         if (i >= 1) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== FW'(32'h100)) begin
               n_errors++;
               $display("FAIL bp_hold[%0d]: valid=%b data=%h want 1 %h",
                        i, out_valid, out_data, FW'(32'h100));
            end
         end
      end
      soma_we = 1'b0;
      n_checks++;
      if (ovf !== 2'b10) begin
         n_errors++;
         $display("FAIL bp_ovf: got %b want 10", ovf);
      end
      ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (out_valid) got.push_back(out_data);
         @(negedge clk);
         if (i == 0) begin
            n_checks++;
            if (soma_full !== 1'b0) begin
               n_errors++;
               $display("FAIL bp_full_fall: got %b want 0", soma_full);
            end
         end
      end
      n_checks++;
      if (got.size() != 5) begin
         n_errors++;
         $display("FAIL bp_count: got %0d flits want 5", got.size());
      end
      for (int i = 0; i < 5 && i < got.size(); i++) begin
         n_checks++;
         if (got[i] !== FW'(32'h100 + i)) begin
            n_errors++;
            $display("FAIL bp_order[%0d]: got %h want %h", i, got[i], FW'(32'h100 + i));
         end
      end
   endtask

   task automatic test_push_pop_same();
      apply_reset();
      ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cfg_we    = 1'b1;
         cfg_wdata = FW'(32'hA0 + i);
         @(negedge clk);
      end
      n_checks++;
      if (u_dut.u_cfg_fifo.count !== 3'd2) begin
         n_errors++;
         $display("FAIL pp_setup_count: got %0d want 2", u_dut.u_cfg_fifo.count);
      end
      ready     = 1'b1;
      cfg_wdata = FW'(32'hA3);
      @(negedge clk);
      cfg_we = 1'b0;
      ready  = 1'b0;
      n_checks++;
      if (u_dut.u_cfg_fifo.count !== 3'd2 || cfg_full !== 1'b0) begin
         n_errors++;
         $display("FAIL pp_count: count=%0d full=%b want 2 0",
                  u_dut.u_cfg_fifo.count, cfg_full);
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cfg_we     = 1'b1;
         cfg_wdata  = FW'(32'hE0 + i);
         soma_we    = (i < 3);
         soma_wdata = FW'(32'hF0 + i);
         @(negedge clk);
      end
      cfg_we  = 1'b0;
      soma_we = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1 || m_cfg.size() != 3 || m_soma.size() != 3) begin
         n_errors++;
         $display("FAIL rm_setup: valid=%b cfg_q=%0d soma_q=%0d want 1 3 3",
                  out_valid, m_cfg.size(), m_soma.size());
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || out_data !== '0 || cfg_full !== 1'b0 ||
          soma_full !== 1'b0 || ovf !== 2'b00) begin
         n_errors++;
         $display("FAIL rm_async: valid=%b data=%h full=%b%b ovf=%b want all 0",
                  out_valid, out_data, cfg_full, soma_full, ovf);
      end
      @(negedge clk);
      rst_n = 1'b1;
      ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         n_checks++;
         if (out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL rm_stale[%0d]: valid=%b data=%h want 0", i, out_valid, out_data);
         end
      end
   endtask

   task automatic test_random_stream();
      logic [FW-1:0] sb_cfg[$];
      logic [FW-1:0] sb_soma[$];
      logic [FW-1:0] exp;
      int unsigned   cfg_seq = 0;
      int unsigned   soma_seq = 0;
      apply_reset();
      for (int cyc = 0; cyc < 400; cyc++) begin
         ready = (cyc % 2 == 0);
         if (out_valid && ready) begin
            n_checks++;
            if (out_data[FW-1]) begin
               if (sb_soma.size() == 0) begin
                  n_errors++;
                  $display("FAIL rnd_soma_extra: got %h want none", out_data);
               end else begin
                  exp = sb_soma.pop_front();
                  if (out_data !== exp) begin
                     n_errors++;
                     $display("FAIL rnd_soma_order: got %h want %h", out_data, exp);
                  end
               end
            end else begin
               if (sb_cfg.size() == 0) begin
                  n_errors++;
                  $display("FAIL rnd_cfg_extra: got %h want none", out_data);
               end else begin
                  exp = sb_cfg.pop_front();
                  if (out_data !== exp) begin
                     n_errors++;
                     $display("FAIL rnd_cfg_order: got %h want %h", out_data, exp);
                  end
               end
            end
         end
         cfg_we     = (cyc < 340) && ($urandom_range(0, 3) != 0);
         cfg_wdata  = FW'(cfg_seq);
         soma_we    = (cyc < 340) && ($urandom_range(0, 3) != 0);
         soma_wdata = FW'(soma_seq) | (FW'(1) << (FW - 1));
         if (cfg_we) begin
            if (m_cfg.size() < DEPTH) sb_cfg.push_back(cfg_wdata);
            cfg_seq++;
         end
         if (soma_we) begin
            if (m_soma.size() < DEPTH) sb_soma.push_back(soma_wdata);
            soma_seq++;
         end
         @(negedge clk);
         n_checks++;
         if (out_valid !== m_valid || (m_valid && out_data !== m_data) ||
             cfg_full !== (m_cfg.size() == DEPTH) || soma_full !== (m_soma.size() == DEPTH) ||
             ovf !== m_ovf) begin
            n_errors++;
            $display("FAIL rnd_cycle[%0d]: valid=%b data=%h full=%b%b ovf=%b want %b %h %b%b %b",
                     cyc, out_valid, out_data, cfg_full, soma_full, ovf, m_valid, m_data,
                     m_cfg.size() == DEPTH, m_soma.size() == DEPTH, m_ovf);
         end
      end
      cfg_we  = 1'b0;
      soma_we = 1'b0;
      n_checks++;
      if (sb_cfg.size() != 0 || sb_soma.size() != 0) begin
         n_errors++;
         $display("FAIL rnd_drain: left cfg=%0d soma=%0d want 0 0", sb_cfg.size(), sb_soma.size());
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_push_pop_same();
      test_reset_mid();
      test_random_stream();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
